timer_irq_scheduler: RTL and testbench

Multi-channel timer scheduler that shares one free-running W-bit counter between NCH software-programmed deadline channels. It arbitrates expired channels round-robin onto a single interrupt line with a channel ID, and holds the line until a CPU acknowledge. It sits between the processor's peripheral bus decode and the interrupt input, replacing per-requester timer instances.

---
 rtl/timer_irq_scheduler.sv | 155 +++++++++++++++
 tb/tb_timer_irq_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_scheduler.sv
// Shared-counter deadline scheduler: NCH channels compared against one free-running
// counter, expiries dispatched round-robin onto a single acknowledged interrupt line.
module timer_irq_scheduler #(
    parameter int NCH = 4,
    parameter int W   = 32,
    parameter int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_wr,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [W-1:0]   cfg_delay,
    input  logic           cfg_periodic,
    input  logic           irq_ack,
    output logic           irq,
    output logic [CW-1:0]  irq_ch,
    output logic [NCH-1:0] armed,
    output logic [NCH-1:0] pending,
    output logic [NCH-1:0] overrun,
    output logic [W-1:0]   now
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_GAP
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_now;
    logic [W-1:0]   r_deadline [NCH];
    logic [W-1:0]   r_period   [NCH];
    logic [NCH-1:0] r_periodic;
    logic [NCH-1:0] r_armed;
    logic [NCH-1:0] r_pending;
    logic [NCH-1:0] r_overrun;
    logic           r_irq;
    logic [CW-1:0]  r_irq_ch;
    logic [CW-1:0]  r_rr_ptr;
    logic           r_ack_q;

    logic           w_ack_edge;
    logic [NCH-1:0] w_expire;
    logic [NCH-1:0] w_in_service;
    logic           w_any;
    logic [CW-1:0]  w_pick;
    logic           w_dispatch;
    logic [CW-1:0]  w_rr_next;

    // First requester at or after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [CW:0] rr_pick(input logic [NCH-1:0] req, input logic [CW-1:0] ptr);
        logic [CW:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!res[CW] && req[idx[CW-1:0]]) res = {1'b1, idx[CW-1:0]};
        end
        return res;
    endfunction

    assign w_ack_edge = irq_ack & ~r_ack_q;
    assign w_rr_next  = (r_irq_ch == CW'(NCH - 1)) ? '0 : r_irq_ch + 1'b1;

    always_comb begin
        w_expire     = '0;
        w_in_service = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_expire[c]     = r_armed[c] && (r_now == r_deadline[c]);
            w_in_service[c] = (r_state == S_ASSERT) && (r_irq_ch == CW'(c));
        end
        {w_any, w_pick} = rr_pick(r_pending, r_rr_ptr);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dispatch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_dispatch  = 1'b1;
                    w_state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: if (w_ack_edge) w_state_nxt = S_GAP;
            S_GAP:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_irq    <= 1'b0;
            r_irq_ch <= '0;
            r_rr_ptr <= '0;
            r_ack_q  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= (w_state_nxt == S_ASSERT);
            r_ack_q <= irq_ack;
            if (w_dispatch) r_irq_ch <= w_pick;
            if (r_state == S_ASSERT && w_ack_edge) r_rr_ptr <= w_rr_next;
        end
    end

    // A write to a channel overrides whatever its expiry or dispatch would do this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_now      <= '0;
            r_periodic <= '0;
            r_armed    <= '0;
            r_pending  <= '0;
            r_overrun  <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                r_deadline[c] <= '0;
                r_period[c]   <= '0;
            end
        end else begin
            r_now <= r_now + 1'b1;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (cfg_wr && cfg_ch == CW'(c)) begin
                    if (cfg_delay != '0) begin
                        r_deadline[c] <= r_now + cfg_delay;
                        r_period[c]   <= cfg_delay;
                        r_periodic[c] <= cfg_periodic;
                        r_armed[c]    <= 1'b1;
                    end else begin
                        r_armed[c]    <= 1'b0;
                    end
                    r_pending[c] <= 1'b0;
                    r_overrun[c] <= 1'b0;
                end else begin
                    if (w_dispatch && w_pick == CW'(c)) r_pending[c] <= 1'b0;
                    if (w_expire[c]) begin
                        if (r_pending[c] || w_in_service[c]) r_overrun[c] <= 1'b1;
                        else                                 r_pending[c] <= 1'b1;
                        if (r_periodic[c]) r_deadline[c] <= r_deadline[c] + r_period[c];
                        else               r_armed[c]    <= 1'b0;
                    end
                end
            end
        end
    end

    assign irq     = r_irq;
    assign irq_ch  = r_irq_ch;
    assign armed   = r_armed;
    assign pending = r_pending;
    assign overrun = r_overrun;
    assign now     = r_now;

endmodule

// File: tb/tb_timer_irq_scheduler.sv
// Bench for timer_irq_scheduler (W=8 build): directed vector table, corner-case
// sequences and randomized traffic against a cycle-level reference model.
module tb_timer_irq_scheduler;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int CW  = 2;
    localparam int unsigned MOD = 1 << W;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_wr;
    logic [CW-1:0]  cfg_ch;
    logic [W-1:0]   cfg_delay;
    logic           cfg_periodic;
    logic           irq_ack;
    logic           irq;
    logic [CW-1:0]  irq_ch;
    logic [NCH-1:0] armed;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] overrun;
    logic [W-1:0]   now;

    always #5 clk = ~clk;

    timer_irq_scheduler #(.NCH(NCH), .W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
        .cfg_periodic(cfg_periodic), .irq_ack(irq_ack), .irq(irq), .irq_ch(irq_ch),
        .armed(armed), .pending(pending), .overrun(overrun), .now(now)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned    m_now;
    int unsigned    m_dl  [NCH];
    int unsigned    m_per [NCH];
    logic [NCH-1:0] m_peri, m_armed, m_pend, m_ovr;
    logic           m_busy, m_gap, m_ackq;
    int unsigned    m_ch, m_rr;

    typedef struct {
        int         pre;
        logic       wr;
        logic [1:0] ch;
        logic [7:0] d;
        logic       per;
        logic       ack;
        logic [7:0] e_now;
        logic       e_irq;
        logic [1:0] e_ch;
        logic [3:0] e_pend;
        logic [3:0] e_arm;
    } vec_t;
    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_now = 0; m_peri = '0; m_armed = '0; m_pend = '0; m_ovr = '0;
        m_busy = 1'b0; m_gap = 1'b0; m_ackq = 1'b0; m_ch = 0; m_rr = 0;
        for (int c = 0; c < NCH; c++) begin
            m_dl[c] = 0; m_per[c] = 0;
        end
    endtask

    task automatic model_step();
        logic           ack_edge, disp, old, svc;
        logic [NCH-1:0] exp_now;
        int unsigned    pick, idx;
        ack_edge = irq_ack && !m_ackq;
        for (int c = 0; c < NCH; c++) exp_now[c] = m_armed[c] && (m_now == m_dl[c]);
        disp = 1'b0;
        pick = 0;
        if (!m_busy && !m_gap) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (m_rr + k) % NCH;
                if (!disp && m_pend[idx]) begin
                    disp = 1'b1;
                    pick = idx;
                end
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (cfg_wr && int'(cfg_ch) == c) begin
                if (cfg_delay != 0) begin
                    m_dl[c]    = (m_now + cfg_delay) % MOD;
                    m_per[c]   = cfg_delay;
                    m_peri[c]  = cfg_periodic;
                    m_armed[c] = 1'b1;
                end else begin
                    m_armed[c] = 1'b0;
                end
                m_pend[c] = 1'b0;
                m_ovr[c]  = 1'b0;
            end else begin
                old = m_pend[c];
                svc = m_busy && (m_ch == c);
                if (disp && pick == c) m_pend[c] = 1'b0;
                if (exp_now[c]) begin
                    if (old || svc) m_ovr[c] = 1'b1;
                    else            m_pend[c] = 1'b1;
                    if (m_peri[c]) m_dl[c] = (m_dl[c] + m_per[c]) % MOD;
                    else           m_armed[c] = 1'b0;
                end
            end
        end
        if (m_gap) m_gap = 1'b0;
        else if (disp) begin
            m_busy = 1'b1;
            m_ch   = pick;
        end else if (m_busy && ack_edge) begin
            m_busy = 1'b0;
            m_rr   = (m_ch + 1) % NCH;
            m_gap  = 1'b1;
        end
        m_ackq = irq_ack;
        m_now  = (m_now + 1) % MOD;
    endtask

    task automatic compare_model();
        chk("now", now, m_now);
        chk("irq", irq, m_busy);
        if (m_busy) chk("irq_ch", irq_ch, m_ch);
        chk("armed", armed, m_armed);
        chk("pending", pending, m_pend);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic cfg(input int ch, input int d, input logic per);
        cfg_wr = 1'b1; cfg_ch = CW'(ch); cfg_delay = W'(d); cfg_periodic = per;
        tick();
        cfg_wr = 1'b0; cfg_delay = '0; cfg_periodic = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < NCH; c++) cfg(c, 0, 1'b0);
        for (int k = 0; k < 60; k++) begin
            irq_ack = irq && !irq_ack;
            tick();
        end
        irq_ack = 1'b0;
        tick();
        chk("drain_irq", irq, 0);
        chk("drain_pending", pending, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           guard, falls, last_rise;
        logic         prev_irq;
        logic [W-1:0] dt;

        vt[0]  = '{10, 1'b1, 2'd0, 8'd5, 1'b0, 1'b0, 8'd11, 1'b0, 2'd0, 4'b0000, 4'b0001};
        vt[1]  = '{ 4, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'd16, 1'b0, 2'd0, 4'b0001, 4'b0000};
        vt[2]  = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'd17, 1'b1, 2'd0, 4'b0000, 4'b0000};
        vt[3]  = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 8'd18, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vt[4]  = '{ 1, 1'b1, 2'd1, 8'd4, 1'b0, 1'b0, 8'd20, 1'b0, 2'd0, 4'b0000, 4'b0010};
        vt[5]  = '{ 0, 1'b1, 2'd2, 8'd3, 1'b0, 1'b0, 8'd21, 1'b0, 2'd0, 4'b0000, 4'b0110};
        vt[6]  = '{ 2, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'd24, 1'b0, 2'd0, 4'b0110, 4'b0000};
        vt[7]  = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'd25, 1'b1, 2'd1, 4'b0100, 4'b0000};
        vt[8]  = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 8'd26, 1'b0, 2'd0, 4'b0100, 4'b0000};
        vt[9]  = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'd27, 1'b0, 2'd0, 4'b0100, 4'b0000};
        vt[10] = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'd28, 1'b1, 2'd2, 4'b0000, 4'b0000};
        vt[11] = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 8'd29, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vt[12] = '{ 0, 1'b1, 2'd1, 8'd3, 1'b0, 1'b0, 8'd30, 1'b0, 2'd0, 4'b0000, 4'b0010};
        vt[13] = '{ 0, 1'b1, 2'd3, 8'd2, 1'b0, 1'b0, 8'd31, 1'b0, 2'd0, 4'b0000, 4'b1010};
        vt[14] = '{ 1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'd33, 1'b0, 2'd0, 4'b1010, 4'b0000};
        vt[15] = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'd34, 1'b1, 2'd3, 4'b0010, 4'b0000};
        vt[16] = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 8'd35, 1'b0, 2'd0, 4'b0010, 4'b0000};
        vt[17] = '{ 1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'd37, 1'b1, 2'd1, 4'b0000, 4'b0000};
        vt[18] = '{ 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 8'd38, 1'b0, 2'd0, 4'b0000, 4'b0000};

        rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_delay = '0; cfg_periodic = 1'b0; irq_ack = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_now", now, 0);
        chk("rst_irq", irq, 0);
        chk("rst_irq_ch", irq_ch, 0);
        chk("rst_armed", armed, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            for (int p = 0; p < vt[i].pre; p++) tick();
            cfg_wr = vt[i].wr; cfg_ch = vt[i].ch; cfg_delay = vt[i].d;
            cfg_periodic = vt[i].per; irq_ack = vt[i].ack;
            tick();
            cfg_wr = 1'b0; cfg_delay = '0; cfg_periodic = 1'b0; irq_ack = 1'b0;
            chk($sformatf("vec%0d_now", i), now, vt[i].e_now);
            chk($sformatf("vec%0d_irq", i), irq, vt[i].e_irq);
            if (vt[i].e_irq) chk($sformatf("vec%0d_irq_ch", i), irq_ch, vt[i].e_ch);
            chk($sformatf("vec%0d_pending", i), pending, vt[i].e_pend);
            chk($sformatf("vec%0d_armed", i), armed, vt[i].e_arm);
        end

        // Periodic channel with prompt acknowledge: fixed spacing, no overrun
        cfg(0, 4, 1'b1);
        prev_irq = 1'b0; last_rise = -1;
        for (int k = 0; k < 40; k++) begin
            irq_ack = irq;
            tick();
            if (irq && !prev_irq) begin
                if (last_rise >= 0) begin
                    dt = now - W'(last_rise);
                    chk("periodic_interval", dt, 4);
                end
                last_rise = int'(now);
            end
            prev_irq = irq;
        end
        irq_ack = 1'b0;
        chk("periodic_overrun_clear", overrun[0], 0);
        for (int k = 0; k < 12; k++) tick();
        chk("periodic_overrun_set", overrun[0], 1);
        chk("periodic_irq_held", irq, 1);
        drain();

        // Deadline crossing the counter wrap
        guard = 0;
        while (now != 8'd250 && guard < 300) begin
            tick();
            guard++;
        end
        chk("wrap_reach_250", now, 250);
        cfg(3, 10, 1'b0);
        guard = 0;
        while (now != 8'd4 && guard < 20) begin
            tick();
            guard++;
        end
        chk("wrap_now4", now, 4);
        chk("wrap_not_yet_pending", pending[3], 0);
        chk("wrap_armed_before", armed[3], 1);
        tick();
        chk("wrap_pending", pending[3], 1);
        chk("wrap_disarmed", armed[3], 0);
        tick();
        chk("wrap_irq", irq, 1);
        chk("wrap_irq_ch", irq_ch, 3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("wrap_ack_drop", irq, 0);

        // Disarm write landing exactly on the expiry cycle
        cfg(2, 6, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        cfg(2, 0, 1'b0);
        chk("collide_pending", pending[2], 0);
        chk("collide_armed", armed[2], 0);
        for (int k = 0; k < 4; k++) tick();
        chk("collide_no_irq", irq, 0);
        chk("collide_no_pending", pending, 0);

        // Level-held acknowledge completes only one service
        cfg(1, 2, 1'b0);
        cfg(0, 1, 1'b0);
        guard = 0;
        while (!irq && guard < 10) begin
            tick();
            guard++;
        end
        chk("hold_irq_seen", irq, 1);
        irq_ack = 1'b1;
        prev_irq = 1'b1; falls = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (prev_irq && !irq) falls++;
            prev_irq = irq;
        end
        chk("hold_one_service", falls, 1);
        chk("hold_second_irq_waits", irq, 1);
        irq_ack = 1'b0;
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("hold_fresh_edge_acks", irq, 0);
        drain();

        // Asynchronous reset while in service with others pending
        cfg(0, 3, 1'b0);
        cfg(1, 4, 1'b0);
        cfg(2, 3, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        chk("rstmid_irq", irq, 1);
        chk("rstmid_irq_ch", irq_ch, 0);
        chk("rstmid_pending", pending, 4'b0110);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_irq_drop", irq, 0);
        chk("rstmid_pending_clr", pending, 0);
        chk("rstmid_armed_clr", armed, 0);
        chk("rstmid_now_clr", now, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rstmid_no_spurious", irq, 0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            int unsigned r;
            cfg_wr = ($urandom_range(0, 7) == 0);
            cfg_ch = CW'($urandom_range(0, NCH - 1));
            r = $urandom_range(0, 9);
            if (r == 0)      cfg_delay = '0;
            else if (r == 1) cfg_delay = W'($urandom_range(1, MOD - 1));
            else if (r == 2) cfg_delay = W'(1);
            else             cfg_delay = W'($urandom_range(2, 16));
            cfg_periodic = 1'($urandom_range(0, 1));
            irq_ack = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
